// File: rtl/video_stream_pkg.sv
// Shared video stream types: pattern modes, field FSM states,
// default SD timing constants and the pixel address packer.
package video_stream_pkg;

  localparam int unsigned DEF_PIX_DIV  = 8;
  localparam int unsigned DEF_H_ACTIVE = 720;
  localparam int unsigned DEF_H_TOTAL  = 864;
  localparam int unsigned DEF_V_ACTIVE = 288;
  localparam int unsigned DEF_V_TOTAL  = 312;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned ADDR_W  = 2 * COORD_W;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [ADDR_W-1:0]  addr_t;

  typedef enum logic [1:0] {
    PAT_RAMP    = 2'd0,
    PAT_BARS    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_FLAT    = 2'd3
  } pattern_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_ACTIVE_FIELD = 2'd1,
    ST_VBLANK       = 2'd2
  } field_state_e;

  function automatic addr_t pack_addr(
    input coord_t line,
    input coord_t pixel
  );
    return {line, pixel};
  endfunction

endpackage

// File: rtl/video_pattern_lut.sv
// Combinational test-pattern generator: mode, pixel, line -> data.
// Only line bit 4 matters (checker squares are 16 pixels/lines).
module video_pattern_lut
  import video_stream_pkg::*;
(
  input  pattern_mode_e mode,
  input  coord_t        pixel,
  input  coord_t        line,
  output logic [7:0]    data
);

  logic line_unused;
  assign line_unused = ^{line[9:5], line[3:0]};

  // Select the pattern value for the current coordinate
  always_comb begin
    data = 8'h00;
    unique case (mode)
      PAT_RAMP:    data = pixel[7:0];
      PAT_BARS:    data = {pixel[9:7], 5'b0};
      PAT_CHECKER: data = (pixel[4] ^ line[4]) ? 8'hFF : 8'h00;
      PAT_FLAT:    data = 8'h80;
    endcase
  end

endmodule

// File: rtl/video_pattern_source.sv
// Field-based test pattern source: pixel divider, h/v counters,
// field FSM and fully registered video outputs.
module video_pattern_source
  import video_stream_pkg::*;
#(
  parameter int unsigned PIX_DIV  = DEF_PIX_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_TOTAL  = DEF_H_TOTAL,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_TOTAL  = DEF_V_TOTAL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  mode,
  output logic        video_frame_valid,
  output logic        video_line_valid,
  output logic        video_data_valid,
  output logic [7:0]  video_data,
  output logic [19:0] video_address,
  output logic        field_odd,
  output logic        field_done
);

  localparam int unsigned DIV_W =
    (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(PIX_DIV - 1);
  localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
  localparam coord_t H_ACT      = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT_LAST = coord_t'(V_ACTIVE - 1);
  localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);

  field_state_e     state;
  field_state_e     state_next;
  pattern_mode_e    field_mode;
  logic [DIV_W-1:0] div_cnt;
  coord_t           h_cnt;
  coord_t           v_cnt;
  logic             tick;
  logic             line_end;
  logic             field_end;
  logic             pix_active;
  logic             enter_field;
  logic [7:0]       lut_data;

  assign tick      = (state != ST_IDLE) && (div_cnt == DIV_LAST);
  assign line_end  = tick && (h_cnt == H_LAST);
  assign field_end = line_end && (v_cnt == V_LAST);

  assign pix_active =
    (state == ST_ACTIVE_FIELD) && (h_cnt < H_ACT);

  assign enter_field =
    (state_next == ST_ACTIVE_FIELD) &&
    (state != ST_ACTIVE_FIELD);

  video_pattern_lut u_lut (
    .mode  (field_mode),
    .pixel (h_cnt),
    .line  (v_cnt),
    .data  (lut_data)
  );

  // Field FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state: a started field always runs through its blanking
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:
        if (enable) state_next = ST_ACTIVE_FIELD;
      ST_ACTIVE_FIELD:
        if (line_end && (v_cnt == V_ACT_LAST))
          state_next = ST_VBLANK;
      ST_VBLANK:
        if (field_end)
          state_next = enable ? ST_ACTIVE_FIELD : ST_IDLE;
      default:
        state_next = ST_IDLE;
    endcase
  end

  // Latch the pattern mode once per field, on field entry
  always_ff @(posedge clk) begin
    if (reset)
      field_mode <= PAT_RAMP;
    else if (enter_field)
      field_mode <= pattern_mode_e'(mode);
  end

  // Pixel divider and h/v raster counters, frozen at 0 in idle
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else if (state != ST_IDLE) begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick)
        h_cnt <= line_end ? '0 : h_cnt + 1'b1;
      if (line_end)
        v_cnt <= field_end ? '0 : v_cnt + 1'b1;
    end
  end

  // Registered outputs, one cycle behind the counter state
  always_ff @(posedge clk) begin
    if (reset) begin
      video_frame_valid <= 1'b0;
      video_line_valid  <= 1'b0;
      video_data_valid  <= 1'b0;
      video_data        <= 8'h00;
      video_address     <= '0;
      field_odd         <= 1'b0;
      field_done        <= 1'b0;
    end else begin
      video_frame_valid <= (state == ST_ACTIVE_FIELD);
      video_line_valid  <= pix_active;
      video_data_valid  <= tick && pix_active;
      field_done        <= field_end;
      field_odd         <= field_odd ^ field_end;
      if (tick && pix_active) begin
        video_data    <= lut_data;
        video_address <= pack_addr(v_cnt, h_cnt);
      end
    end
  end

endmodule

// File: tb/tb_video_pattern_source.sv
// Bench for video_pattern_source: field-time reference model checked
// every cycle, plus literal expectations on field timing and scenarios.
module tb_video_pattern_source;

  localparam int PD = 2;
  localparam int HA = 4;
  localparam int HT = 6;
  localparam int VA = 3;
  localparam int VT = 4;
  localparam int FIELD = PD * HT * VT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        video_frame_valid;
  logic        video_line_valid;
  logic        video_data_valid;
  logic [7:0]  video_data;
  logic [19:0] video_address;
  logic        field_odd;
  logic        field_done;

  int vectors = 0;
  int miscompares = 0;

  video_pattern_source #(
    .PIX_DIV  (PD),
    .H_ACTIVE (HA),
    .H_TOTAL  (HT),
    .V_ACTIVE (VA),
    .V_TOTAL  (VT)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .mode              (mode),
    .video_frame_valid (video_frame_valid),
    .video_line_valid  (video_line_valid),
    .video_data_valid  (video_data_valid),
    .video_data        (video_data),
    .video_address     (video_address),
    .field_odd         (field_odd),
    .field_done        (field_done)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] outs();
    return {video_frame_valid, video_line_valid,
            video_data_valid, video_data, video_address,
            field_odd, field_done};
  endfunction

  function automatic logic [7:0] pat(input int m,
                                     input int p,
                                     input int l);
    case (m)
      0: return 8'(p % 256);
      1: return 8'((p / 128) * 32);
      2: return (((p / 16) % 2) != ((l / 16) % 2))
                ? 8'hFF : 8'h00;
      default: return 8'h80;
    endcase
  endfunction

  // Reference model: a field is FIELD clocks indexed by m_t
  bit          m_run = 0;
  int          m_t = 0;
  int          m_mode = 0;
  bit          m_odd = 0;
  logic [7:0]  m_data = 8'h00;
  logic [19:0] m_addr = '0;
  bit          e_fv, e_lv, e_dv, e_fd;

  always @(posedge clk) begin
    int ph, pix, ln;
    logic [32:0] exp_v, act_v;
    if (reset) begin
      m_run = 0; m_t = 0; m_odd = 0;
      m_data = 8'h00; m_addr = '0;
      e_fv = 0; e_lv = 0; e_dv = 0; e_fd = 0;
    end else if (!m_run) begin
      e_fv = 0; e_lv = 0; e_dv = 0; e_fd = 0;
      if (enable) begin
        m_run = 1; m_t = 0; m_mode = int'(mode);
      end
    end else begin
      ph  = m_t % PD;
      pix = (m_t / PD) % HT;
      ln  = m_t / (PD * HT);
      e_fv = (ln < VA);
      e_lv = e_fv && (pix < HA);
      e_dv = e_lv && (ph == PD - 1);
      if (e_dv) begin
        m_data = pat(m_mode, pix, ln);
        m_addr = {10'(ln), 10'(pix)};
      end
      e_fd = (m_t == FIELD - 1);
      if (e_fd) begin
        m_odd = !m_odd;
        m_t = 0;
        if (enable) m_mode = int'(mode);
        else        m_run = 0;
      end else begin
        m_t++;
      end
    end
    #1;
    exp_v = {e_fv, e_lv, e_dv, m_data, m_addr, m_odd, e_fd};
    act_v = outs();
    vectors++;
    if (act_v !== exp_v) begin
      miscompares++;
      $display("FAIL cycle_cmp t=%0t act=%h exp=%h",
               $time, act_v, exp_v);
    end
  end

  task automatic chk(input string name, input int act,
                     input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // DUT-derived statistics gathered on the falling edge
  int          cyc = 0;
  int          strobes = 0;
  int          n80 = 0;
  int          fv_low = 0;
  int          lv_run = 0;
  int          strobe_cyc[$];
  logic [19:0] strobe_addr[$];
  int          lv_runs[$];
  int          fd_cyc[$];
  int          fd_strobes[$];
  int          fd_n80[$];
  int          fd_fvlow[$];
  int          odd_seq[$];

  task automatic clear_stats();
    strobes = 0; n80 = 0; fv_low = 0; lv_run = 0;
    strobe_cyc.delete(); strobe_addr.delete();
    lv_runs.delete(); fd_cyc.delete();
    fd_strobes.delete(); fd_n80.delete();
    fd_fvlow.delete(); odd_seq.delete();
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (video_data_valid) begin
      strobes++;
      if (video_data == 8'h80) n80++;
      strobe_cyc.push_back(cyc);
      strobe_addr.push_back(video_address);
    end
    if (!video_frame_valid) fv_low++;
    if (video_line_valid) begin
      lv_run++;
    end else if (lv_run != 0) begin
      lv_runs.push_back(lv_run);
      lv_run = 0;
    end
    if (field_done) begin
      fd_cyc.push_back(cyc);
      fd_strobes.push_back(strobes);
      fd_n80.push_back(n80);
      fd_fvlow.push_back(fv_low);
      odd_seq.push_back(int'(field_odd));
      strobes = 0; n80 = 0; fv_low = 0;
    end
  endtask

  task automatic wait_fields(input int n, input int budget,
                             input string tag);
    int k = 0;
    while (fd_cyc.size() < n && k < budget) begin
      step();
      k++;
    end
    if (fd_cyc.size() < n)
      chk({tag, "_timeout"}, fd_cyc.size(), n);
  endtask

  task automatic wait_addr(input logic [19:0] a,
                           input int budget,
                           input string tag);
    bit hit = 0;
    int k = 0;
    while (!hit && k < budget) begin
      step();
      k++;
      if (video_data_valid && video_address == a) hit = 1;
    end
    if (!hit) chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    logic [19:0] ea;
    int k;

    // Reset state
    repeat (3) step();
    chk("reset_outs", int'(outs()), 0);
    reset = 1'b0;
    step();
    chk("idle_outs", int'(outs()), 0);

    // Continuous ramp over three fields
    clear_stats();
    chk("odd_initial", int'(field_odd), 0);
    enable = 1'b1;
    mode = 2'd0;
    wait_fields(3, 200, "ramp");
    if (fd_cyc.size() >= 3) begin
      for (int i = 0; i < 3; i++)
        chk("strobes_per_field", fd_strobes[i], 12);
      chk("fd_interval_1", fd_cyc[1] - fd_cyc[0], FIELD);
      chk("fd_interval_2", fd_cyc[2] - fd_cyc[1], FIELD);
      chk("fv_low_f2", fd_fvlow[1], 12);
      chk("fv_low_f3", fd_fvlow[2], 12);
      chk("odd_f1", odd_seq[0], 1);
      chk("odd_f2", odd_seq[1], 0);
      chk("odd_f3", odd_seq[2], 1);
    end
    if (strobe_addr.size() >= 12) begin
      for (int i = 0; i < 12; i++) begin
        ea = {10'(i / 4), 10'(i % 4)};
        chk("f1_addr", int'(strobe_addr[i]), int'(ea));
      end
      chk("strobe_gap", strobe_cyc[1] - strobe_cyc[0], 2);
    end
    chk("lv_runs_seen", lv_runs.size(), 9);
    foreach (lv_runs[i]) chk("lv_run_len", lv_runs[i], 8);

    // Mode change mid-field only affects the next field
    clear_stats();
    wait_addr({10'd1, 10'd0}, 100, "mid_mode");
    mode = 2'd3;
    wait_fields(2, 150, "flat");
    if (fd_cyc.size() >= 2) begin
      chk("cur_field_n80", fd_n80[0], 0);
      chk("next_field_n80", fd_n80[1], 12);
      chk("next_field_strobes", fd_strobes[1], 12);
    end

    // Random mode churn while running
    for (int i = 0; i < 300; i++) begin
      step();
      mode = 2'($urandom_range(0, 3));
    end

    // Enable dropped on line 1: field completes, then idle
    mode = 2'd0;
    clear_stats();
    wait_addr({10'd1, 10'd0}, 100, "drop");
    enable = 1'b0;
    wait_fields(1, 100, "drop_end");
    if (strobe_addr.size() > 0)
      chk("last_addr", int'(strobe_addr[$]),
          int'({10'd2, 10'd3}));
    clear_stats();
    repeat (30) step();
    chk("idle_strobes", strobe_addr.size(), 0);
    chk("idle_fv_low", fv_low, 30);
    chk("idle_fd", fd_cyc.size(), 0);

    // Reset at line 1, pixel 2
    enable = 1'b1;
    wait_addr({10'd1, 10'd2}, 100, "rst_pt");
    reset = 1'b1;
    step();
    chk("rst_outs", int'(outs()), 0);
    reset = 1'b0;
    clear_stats();
    k = 0;
    while (strobe_addr.size() == 0 && k < 20) begin
      step();
      k++;
    end
    if (strobe_addr.size() == 0)
      chk("rst_restart_timeout", 0, 1);
    else
      chk("addr_after_rst", int'(strobe_addr[0]), 0);

    // Random reset/enable/mode traffic
    for (int i = 0; i < 1500; i++) begin
      step();
      reset  = ($urandom_range(0, 99) == 0);
      enable = ($urandom_range(0, 9) != 0);
      mode   = 2'($urandom_range(0, 3));
    end
    reset = 1'b0;
    enable = 1'b0;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
